// File: rtl/ppu_timing_ctrl.sv
// ppu_timing_ctrl
// Scanline/dot scheduler for the PPU. It walks the dot (lx) and line (ly)
// counters, derives the PPU mode, raises the VBlank and STAT interrupt
// requests, and grants CPU access to VRAM/OAM according to the mode.
//
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   lcd_ena        LCDC bit 7; low holds the timing at line 0, dot 0
//   lyc            LY compare value
//   stat_ie        STAT enables {lyc, oam, vblank, hblank}
//   draw_done      fetcher pulse: last pixel of the line has been pushed
//   draw_start     one-cycle pulse on the first mode-3 cycle
//   ly, lx         current line and dot
//   mode           0=HBlank, 1=VBlank, 2=OAM scan, 3=draw
//   stat_out       STAT register view {1, stat_ie, ly_eq, mode}
//   irq_vblank     one-cycle VBlank interrupt request
//   irq_stat       one-cycle STAT interrupt request
//   cpu_vram_ok    CPU may access VRAM
//   cpu_oam_ok     CPU may access OAM
//
// mode        | meaning
// ------------+--------------------------------------------------
// MODE_OAM    | lx < OAM_DOTS on a visible line, OAM scan
// MODE_DRAW   | drawing flag set, pixel fetcher owns VRAM and OAM
// MODE_HBLANK | rest of a visible line, or LCD off / in reset
// MODE_VBLANK | ly >= VISIBLE_LINES
module ppu_timing_ctrl #(
   parameter int DOTS_PER_LINE   = 456,
   parameter int LINES_PER_FRAME = 154,
   parameter int VISIBLE_LINES   = 144,
   parameter int OAM_DOTS        = 80,
   parameter int MAX_DRAW        = 289
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       lcd_ena,
   input  logic [7:0] lyc,
   input  logic [3:0] stat_ie,
   input  logic       draw_done,
   output logic       draw_start,
   output logic [7:0] ly,
   output logic [8:0] lx,
   output logic [1:0] mode,
   output logic [7:0] stat_out,
   output logic       irq_vblank,
   output logic       irq_stat,
   output logic       cpu_vram_ok,
   output logic       cpu_oam_ok
);

   typedef enum logic [1:0] {
      MODE_HBLANK = 2'd0,
      MODE_VBLANK = 2'd1,
      MODE_OAM    = 2'd2,
      MODE_DRAW   = 2'd3
   } mode_t;

   localparam logic [8:0] LX_LAST      = 9'(DOTS_PER_LINE - 1);
   localparam logic [8:0] LX_OAM_LAST  = 9'(OAM_DOTS - 1);
   localparam logic [8:0] LX_OAM       = 9'(OAM_DOTS);
   localparam logic [8:0] LX_DRAW_LAST = 9'(OAM_DOTS + MAX_DRAW - 1);
   localparam logic [7:0] LY_LAST      = 8'(LINES_PER_FRAME - 1);
   localparam logic [7:0] LY_VIS       = 8'(VISIBLE_LINES);
   localparam logic [7:0] LY_VIS_PREV  = 8'(VISIBLE_LINES - 1);

   logic  drawing;
   logic  stat_line_q;
   logic  stat_line;
   logic  ly_eq;
   logic  line_wrap;
   logic  draw_set;
   logic  draw_clr;
   mode_t mode_c;

   assign line_wrap = (lx == LX_LAST);
   assign draw_set  = (lx == LX_OAM_LAST) && (ly < LY_VIS);
   // draw_done only matters while drawing, which keeps it ignored outside mode 3
   assign draw_clr  = (drawing && draw_done) || (lx == LX_DRAW_LAST) || line_wrap;
   assign ly_eq     = (ly == lyc);

   // Counters sit at 0,0 while disabled or in reset, so mode is gated here
   // to read HBlank rather than OAM scan in those states.
   always_comb begin
      mode_c = MODE_HBLANK;
      if (lcd_ena && reset_n) begin
         if (ly >= LY_VIS)
            mode_c = MODE_VBLANK;
         else if (lx < LX_OAM)
            mode_c = MODE_OAM;
         else if (drawing)
            mode_c = MODE_DRAW;
         else
            mode_c = MODE_HBLANK;
      end
   end

   assign mode      = mode_c;
   assign stat_line = lcd_ena & ((stat_ie[0] & (mode_c == MODE_HBLANK)) |
                                 (stat_ie[1] & (mode_c == MODE_VBLANK)) |
                                 (stat_ie[2] & (mode_c == MODE_OAM))    |
                                 (stat_ie[3] & ly_eq));
   assign stat_out    = {1'b1, stat_ie, ly_eq, mode_c};
   assign cpu_vram_ok = (mode_c != MODE_DRAW);
   assign cpu_oam_ok  = (mode_c == MODE_HBLANK) || (mode_c == MODE_VBLANK);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lx          <= '0;
         ly          <= '0;
         drawing     <= 1'b0;
         stat_line_q <= 1'b0;
         draw_start  <= 1'b0;
         irq_vblank  <= 1'b0;
         irq_stat    <= 1'b0;
      end else if (!lcd_ena) begin
         lx          <= '0;
         ly          <= '0;
         drawing     <= 1'b0;
         stat_line_q <= 1'b0;
         draw_start  <= 1'b0;
         irq_vblank  <= 1'b0;
         irq_stat    <= 1'b0;
      end else begin
         if (line_wrap) begin
            lx <= '0;
            ly <= (ly == LY_LAST) ? 8'd0 : ly + 8'd1;
         end else begin
            lx <= lx + 9'd1;
         end
         // set has priority over any coincident clear
         drawing     <= draw_set | (drawing & ~draw_clr);
         draw_start  <= draw_set;
         irq_vblank  <= line_wrap && (ly == LY_VIS_PREV);
         // rising-edge detect gives STAT blocking across source changes
         irq_stat    <= stat_line & ~stat_line_q;
         stat_line_q <= stat_line;
      end
   end

endmodule

// File: tb/tb_ppu_timing_ctrl.sv
module tb_ppu_timing_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       lcd_ena;
   logic [7:0] lyc;
   logic [3:0] stat_ie;
   logic       draw_done;
   logic       draw_start;
   logic [7:0] ly;
   logic [8:0] lx;
   logic [1:0] mode;
   logic [7:0] stat_out;
   logic       irq_vblank;
   logic       irq_stat;
   logic       cpu_vram_ok;
   logic       cpu_oam_ok;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   ppu_timing_ctrl dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .lcd_ena     (lcd_ena),
      .lyc         (lyc),
      .stat_ie     (stat_ie),
      .draw_done   (draw_done),
      .draw_start  (draw_start),
      .ly          (ly),
      .lx          (lx),
      .mode        (mode),
      .stat_out    (stat_out),
      .irq_vblank  (irq_vblank),
      .irq_stat    (irq_stat),
      .cpu_vram_ok (cpu_vram_ok),
      .cpu_oam_ok  (cpu_oam_ok)
   );

   function automatic int elx();
      return cyc % 456;
   endfunction

   function automatic int ely();
      return (cyc / 456) % 154;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset_n && lcd_ena) cyc++;
      else cyc = 0;
      #1;
   endtask

   task automatic run_to(input int ty, input int tx);
      int guard;
      guard = 0;
      while (!(ely() == ty && elx() == tx) && guard < 80000) begin
         tick();
         guard++;
      end
      chk("pos_ly", 32'(ly), 32'(ty));
      chk("pos_lx", 32'(lx), 32'(tx));
   endtask

   initial begin
      reset_n   = 1'b0;
      lcd_ena   = 1'b0;
      draw_done = 1'b0;
      lyc       = 8'd5;
      stat_ie   = 4'b0001;
      tick();
      tick();
      chk("rst_ly", ly, 0);
      chk("rst_lx", lx, 0);
      chk("rst_mode", mode, 0);
      chk("rst_vram_ok", cpu_vram_ok, 1);
      chk("rst_oam_ok", cpu_oam_ok, 1);
      chk("rst_irq_vblank", irq_vblank, 0);
      chk("rst_irq_stat", irq_stat, 0);
      chk("rst_draw_start", draw_start, 0);

      // LCD off: HBlank enable would raise stat_line, but it is forced low
      reset_n = 1'b1;
      repeat (4) begin
         tick();
         chk("dis_irq_stat", irq_stat, 0);
         chk("dis_lx", lx, 0);
         chk("dis_mode", mode, 0);
      end
      chk("dis_ly", ly, 0);
      chk("dis_stat_out", stat_out, 8'h88);
      chk("dis_vram_ok", cpu_vram_ok, 1);
      chk("dis_oam_ok", cpu_oam_ok, 1);
      chk("dis_irq_vblank", irq_vblank, 0);

      // line 0 with fetcher handshake
      lcd_ena = 1'b1;
      #1;
      for (int i = 0; i < 80; i++) begin
         chk("oam_mode", mode, 2);
         chk("oam_lx", lx, i);
         chk("oam_oam_ok", cpu_oam_ok, 0);
         chk("oam_vram_ok", cpu_vram_ok, 1);
         tick();
      end
      chk("draw_mode", mode, 3);
      chk("draw_start", draw_start, 1);
      chk("draw_vram_ok", cpu_vram_ok, 0);
      chk("draw_oam_ok", cpu_oam_ok, 0);
      chk("draw_stat_out", stat_out, 8'h8B);
      draw_done = 1'b1;
      tick();
      draw_done = 1'b0;
      chk("hb_lx", lx, 81);
      chk("hb_mode", mode, 0);
      chk("hb_draw_start", draw_start, 0);
      chk("hb_vram_ok", cpu_vram_ok, 1);
      chk("hb_oam_ok", cpu_oam_ok, 1);
      chk("hb_irq_early", irq_stat, 0);
      tick();
      chk("hb_irq_stat", irq_stat, 1);
      tick();
      chk("hb_irq_once", irq_stat, 0);
      run_to(0, 455);
      chk("eol_mode", mode, 0);
      tick();
      chk("wrap_ly", ly, 1);
      chk("wrap_lx", lx, 0);
      chk("wrap_mode", mode, 2);

      // line 1: no draw_done, timeout
      run_to(1, 80);
      chk("to_start", mode, 3);
      run_to(1, 368);
      chk("to_last", mode, 3);
      tick();
      chk("to_end_lx", lx, 369);
      chk("to_end_mode", mode, 0);
      run_to(1, 400);
      draw_done = 1'b1;
      tick();
      draw_done = 1'b0;
      chk("late_done_mode", mode, 0);
      chk("late_done_lx", lx, 401);
      chk("late_done_ly", ly, 1);
      chk("late_done_start", draw_start, 0);

      // LYC-only STAT source
      run_to(3, 400);
      stat_ie = 4'b1000;
      run_to(4, 455);
      chk("lyc_pre_irq", irq_stat, 0);
      chk("lyc_pre_eq", stat_out[2], 0);
      tick();
      chk("lyc_ly", ly, 5);
      chk("lyc_stat_out", stat_out, 8'hC6);
      chk("lyc_irq_lag", irq_stat, 0);
      tick();
      chk("lyc_irq", irq_stat, 1);
      repeat (454) begin
         tick();
         chk("lyc_once", irq_stat, 0);
      end

      // STAT blocking: HBlank of line 6 flows straight into LYC match on line 7
      run_to(6, 10);
      lyc     = 8'd7;
      stat_ie = 4'b1001;
      run_to(6, 369);
      chk("blk_hb_mode", mode, 0);
      chk("blk_hb_lag", irq_stat, 0);
      tick();
      chk("blk_hb_irq", irq_stat, 1);
      run_to(7, 0);
      chk("blk_stat_out", stat_out, 8'hCE);
      tick();
      chk("blk_no_retrig", irq_stat, 0);
      repeat (454) begin
         tick();
         chk("blk_line7", irq_stat, 0);
      end

      // VBlank entry and frame wrap
      stat_ie = 4'b0000;
      lyc     = 8'd5;
      run_to(143, 455);
      chk("vb_pre_irq", irq_vblank, 0);
      chk("vb_pre_mode", mode, 0);
      tick();
      chk("vb_ly", ly, 144);
      chk("vb_lx", lx, 0);
      chk("vb_mode", mode, 1);
      chk("vb_irq", irq_vblank, 1);
      chk("vb_vram_ok", cpu_vram_ok, 1);
      chk("vb_oam_ok", cpu_oam_ok, 1);
      tick();
      chk("vb_irq_once", irq_vblank, 0);
      chk("vb_mode2", mode, 1);
      run_to(153, 455);
      chk("vb_last_mode", mode, 1);
      chk("vb_last_irq", irq_vblank, 0);
      tick();
      chk("frame_ly", ly, 0);
      chk("frame_lx", lx, 0);
      chk("frame_mode", mode, 2);
      chk("frame_irq", irq_vblank, 0);

      // reset mid-frame while drawing, with a STAT pulse in flight
      run_to(10, 199);
      lyc     = 8'd10;
      stat_ie = 4'b1000;
      tick();
      chk("mid_mode", mode, 3);
      chk("mid_irq_stat", irq_stat, 1);
      reset_n = 1'b0;
      cyc     = 0;
      #1;
      chk("mid_rst_ly", ly, 0);
      chk("mid_rst_lx", lx, 0);
      chk("mid_rst_mode", mode, 0);
      chk("mid_rst_irq_stat", irq_stat, 0);
      chk("mid_rst_irq_vb", irq_vblank, 0);
      chk("mid_rst_vram_ok", cpu_vram_ok, 1);
      chk("mid_rst_oam_ok", cpu_oam_ok, 1);
      tick();
      chk("mid_hold_mode", mode, 0);
      chk("mid_hold_lx", lx, 0);
      lyc     = 8'd5;
      stat_ie = 4'b0000;
      reset_n = 1'b1;
      #1;
      chk("restart_ly", ly, 0);
      chk("restart_lx", lx, 0);
      chk("restart_mode", mode, 2);
      run_to(0, 80);
      chk("restart_draw", mode, 3);
      chk("restart_start", draw_start, 1);

      // LCD off mid-line
      run_to(0, 300);
      chk("off_pre_mode", mode, 3);
      lcd_ena = 1'b0;
      #1;
      chk("off_mode", mode, 0);
      chk("off_vram_ok", cpu_vram_ok, 1);
      chk("off_oam_ok", cpu_oam_ok, 1);
      tick();
      chk("off_lx", lx, 0);
      chk("off_ly", ly, 0);
      chk("off_irq_stat", irq_stat, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
